// File: rtl/sram_bytelane_if.sv
// Bus between a CPU-side master and the byte-lane SRAM.
// The requester drives the master side and the memory drives the slave side.
interface sram_bytelane_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  sram_en;
  logic [NB-1:0]         sram_wen;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic                  sram_rvalid;
  logic                  sram_addr_err;

  modport master (
    output sram_en,
    output sram_wen,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata,
    input  sram_rvalid,
    input  sram_addr_err
  );

  modport slave (
    input  sram_en,
    input  sram_wen,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata,
    output sram_rvalid,
    output sram_addr_err
  );
endinterface

// File: rtl/sram_bytelane.sv
// Single-port synchronous SRAM with per-byte write enables, selectable
// read-during-write behaviour, a 1- or 2-stage read pipeline with a valid
// strobe, and out-of-range address detection.
// Every accepted access is also a read; memory contents are never reset.
module sram_bytelane #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4096,
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic          clk,
  input  logic          reset,
  sram_bytelane_if.slave bus
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W     = ADDR_WIDTH - LANE_BITS;
  localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // When DEPTH fills the whole index space no address can be out of range.
  localparam bit OOR_POSSIBLE = (longint'(DEPTH) < (longint'(1) << IDX_W));
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

  // Illegal parameter combinations stop elaboration.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_bytelane: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("sram_bytelane: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || !(longint'(DEPTH) <= (longint'(1) << IDX_W))) begin : g_bad_depth
    $error("sram_bytelane: DEPTH must be between 1 and the addressable word count");
  end
  if (WRITE_FIRST != 0 && WRITE_FIRST != 1) begin : g_bad_wf
    $error("sram_bytelane: WRITE_FIRST must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      acc_idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  acc_oor;
  logic                  acc_wr;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] read_word;

  logic                  s1_valid;
  logic                  s1_err;
  logic [DATA_WIDTH-1:0] s1_data;

  // Word index from the byte address; the lane-select bits are dropped.
  assign acc_idx = bus.sram_addr[ADDR_WIDTH-1:LANE_BITS];
  assign mem_idx = acc_idx[MEM_AW-1:0];

  if (LANE_BITS > 0) begin : g_lane_bits
    logic unused_lane_bits;
    assign unused_lane_bits = ^bus.sram_addr[LANE_BITS-1:0];
  end

  // Index is zero-extended before the compare so DEPTH == 2^IDX_W cannot wrap.
  if (OOR_POSSIBLE) begin : g_range_chk
    assign acc_oor = ({1'b0, acc_idx} >= DEPTH_C);
  end else begin : g_range_full
    assign acc_oor = 1'b0;
  end

  assign old_word = mem[mem_idx];

  // Merged word: enabled lanes from the write data, the rest from memory.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (bus.sram_wen[i]) merged_word[8*i +: 8] = bus.sram_wdata[8*i +: 8];
    end
  end

  // Out-of-range reads return zero; otherwise old or merged word by build.
  assign read_word = acc_oor ? '0 : ((WRITE_FIRST != 0) ? merged_word : old_word);

  // A low reset at the accepting edge blocks the write, as does a bad address.
  assign acc_wr = reset && bus.sram_en && !acc_oor;

  // Byte-lane write port, kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (acc_wr && bus.sram_wen[i]) mem[mem_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
    end
  end

  // First read stage: capture the selected word and tag it valid/error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= bus.sram_en;
      s1_err   <= bus.sram_en & acc_oor;
      if (bus.sram_en) s1_data <= read_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic                  s2_err;
    logic [DATA_WIDTH-1:0] s2_data;

    // Output stage: data moves only with a valid result so rdata holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s2_valid <= 1'b0;
        s2_err   <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_err   <= s1_err;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign bus.sram_rdata    = s2_data;
    assign bus.sram_rvalid   = s2_valid;
    assign bus.sram_addr_err = s2_err;
  end else begin : g_lat1
    assign bus.sram_rdata    = s1_data;
    assign bus.sram_rvalid   = s1_valid;
    assign bus.sram_addr_err = s1_err;
  end

endmodule
